// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of a multi-cycle MIPS datapath.
//
// A single shared memory serves instruction fetch and data access, and the
// ALU and PC register are reused from cycle to cycle. Each instruction is
// sequenced through fetch, decode, execute, memory and writeback states.
// Datapath enables and mux selects are decoded from the current state. The
// only input-dependent qualifiers are the memory-ready handshake and the
// opcode or funct field that selects a variant of a state.
//
// Memory handshake: in FETCH, MREAD and MWRITE the request (mem_read_o or
// mem_write_o) is held high. The access completes in the first cycle where
// mem_ready_i is high. Only in that cycle are the commit strobes
// (ir_write_o/pc_write_o) asserted, and only on that edge does the FSM move
// on. If mem_ready_i stays low for TMO_CYCLES cycles, the access is
// abandoned: mem_err_o pulses and the FSM returns to FETCH.
//
// Optional build macro: MULTICYCLE_PERF_CNT_EN adds the cycle_cnt_o and
// instr_cnt_o performance counters. Without it, neither the ports nor the
// counter logic exist.

module multicycle_ctrl #(
    parameter int unsigned TMO_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_beq_o,
    output logic       pc_write_bne_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic [3:0] state_o,
    output logic       illegal_o,
    output logic       mem_err_o
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instr_cnt_o
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MREAD  = 4'd3,
        S_MWB    = 4'd4,
        S_MWRITE = 4'd5,
        S_REXE   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXE   = 4'd10,
        S_IWB    = 4'd11,
        S_JR     = 4'd12,
        S_JAL    = 4'd13,
        S_RST    = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Last wait-count value before a memory access is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    state_e     dec_state;
    logic       dec_illegal;
    logic       in_wait_state;
    logic       tmo_hit;

    assign state_o = state_q;

    // A memory state gives up when the count has reached its limit and
    // ready is still low. If ready is high in that cycle, the access completes.
    assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MREAD) ||
                           (state_q == S_MWRITE);
    assign tmo_hit = in_wait_state && !mem_ready_i && (wait_cnt_q == TMO_LAST);

    // State and wait counter registers; reset aborts any instruction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_RST;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Opcode dispatch used by DECODE: target state plus the unsupported flag.
    always_comb begin
        dec_state   = S_FETCH;
        dec_illegal = 1'b0;
        case (opcode_i)
            OP_RTYPE:         dec_state = (funct_i == FN_JR) ? S_JR : S_REXE;
            OP_LW, OP_SW:     dec_state = S_MADDR;
            OP_BEQ, OP_BNE:   dec_state = S_BRANCH;
            OP_J:             dec_state = S_JUMP;
            OP_JAL:           dec_state = S_JAL;
            OP_ADDI, OP_SLTI: dec_state = S_IEXE;
            default: begin
                dec_state   = S_FETCH;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: state_d = dec_state;
            S_MADDR:  state_d = (opcode_i == OP_SW) ? S_MWRITE : S_MREAD;
            S_MREAD: begin
                if (mem_ready_i) begin
                    state_d = S_MWB;
                end else if (tmo_hit) begin
                    state_d = S_FETCH;
                end
            end
            S_MWB:    state_d = S_FETCH;
            S_MWRITE: begin
                if (mem_ready_i || tmo_hit) begin
                    state_d = S_FETCH;
                end
            end
            S_REXE:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_JAL:    state_d = S_FETCH;
            S_JR:     state_d = S_FETCH;
            S_IEXE:   state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Wait counter: cleared on every state entry (a timeout re-entering
    // FETCH counts as a new entry), and advanced while a memory state is
    // stalled.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_d != state_q) || tmo_hit) begin
            wait_cnt_d = '0;
        end else if (in_wait_state && !mem_ready_i) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Output decode; anything not set for a state stays 0.
    always_comb begin
        pc_write_o     = 1'b0;
        pc_write_beq_o = 1'b0;
        pc_write_bne_o = 1'b0;
        iord_o         = 1'b0;
        mem_read_o     = 1'b0;
        mem_write_o    = 1'b0;
        ir_write_o     = 1'b0;
        reg_dst_o      = 2'd0;
        mem_to_reg_o   = 2'd0;
        reg_write_o    = 1'b0;
        alu_src_a_o    = 1'b0;
        alu_src_b_o    = 2'd0;
        alu_op_o       = 3'd0;
        pc_source_o    = 2'd0;
        illegal_o      = 1'b0;
        mem_err_o      = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 computed in the ALU; commit only when memory answers.
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'd1;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                mem_err_o   = tmo_hit;
            end
            S_DECODE: begin
                // Branch target goes into ALUOut speculatively.
                alu_src_b_o = 2'd3;
                illegal_o   = dec_illegal;
            end
            S_MADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
            end
            S_MREAD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                mem_err_o  = tmo_hit;
            end
            S_MWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'd1;
            end
            S_MWRITE: begin
                // The write strobe is withdrawn in the cycle the store is abandoned.
                mem_write_o = !tmo_hit;
                iord_o      = 1'b1;
                mem_err_o   = tmo_hit;
            end
            S_REXE: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'd2;
            end
            S_RWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 2'd1;
            end
            S_BRANCH: begin
                alu_src_a_o    = 1'b1;
                alu_op_o       = 3'd1;
                pc_source_o    = 2'd1;
                pc_write_beq_o = (opcode_i == OP_BEQ);
                pc_write_bne_o = (opcode_i == OP_BNE);
            end
            S_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = 2'd2;
            end
            S_JAL: begin
                // PC already holds PC+4, which is the link value written to $31.
                pc_write_o   = 1'b1;
                pc_source_o  = 2'd2;
                reg_write_o  = 1'b1;
                reg_dst_o    = 2'd2;
                mem_to_reg_o = 2'd3;
            end
            S_JR: begin
                pc_write_o  = 1'b1;
                pc_source_o = 2'd3;
            end
            S_IEXE: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_op_o    = (opcode_i == OP_SLTI) ? 3'd3 : 3'd0;
            end
            S_IWB: begin
                reg_write_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic        instr_done;

    assign cycle_cnt_o = cycle_cnt_q;
    assign instr_cnt_o = instr_cnt_q;

    // An instruction retires when a final state hands back to FETCH.
    // Illegal-opcode and timeout returns do not retire anything.
    assign instr_done = (state_d == S_FETCH) && !tmo_hit &&
                        (state_q inside {S_MWB, S_MWRITE, S_RWB, S_BRANCH,
                                         S_JUMP, S_JAL, S_JR, S_IWB});

    // Free-running counters; both wrap naturally at 2^32.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != S_RST) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if (instr_done) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Instance dut uses TMO_CYCLES=16.
// Instance dut4 uses TMO_CYCLES=4 and exercises the timeout paths.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit later.

module tb_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ready_a;
  logic       ready_b;

  int n_checks;
  int n_pass;

  // Control vector packing:
  // {pc_write, beq, bne, iord, mem_read, mem_write, ir_write, reg_dst[2],
  //  mem_to_reg[2], reg_write, src_a, src_b[2], alu_op[3], pc_source[2],
  //  illegal, mem_err}
  localparam logic [21:0] E_ZERO      = '0;
  localparam logic [21:0] E_FETCH_RDY = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'd0,2'd0,1'b0,1'b0,2'd1,3'd0,2'd0,1'b0,1'b0};
  localparam logic [21:0] E_FETCH_WT  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd1,3'd0,2'd0,1'b0,1'b0};
  localparam logic [21:0] E_FETCH_TMO = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd1,3'd0,2'd0,1'b0,1'b1};
  localparam logic [21:0] E_DECODE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd3,3'd0,2'd0,1'b0,1'b0};
  localparam logic [21:0] E_DEC_ILL   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd3,3'd0,2'd0,1'b1,1'b0};
  localparam logic [21:0] E_MADDR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,2'd2,3'd0,2'd0,1'b0,1'b0};
  localparam logic [21:0] E_MREAD     = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,3'd0,2'd0,1'b0,1'b0};
  localparam logic [21:0] E_MREAD_TMO = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,3'd0,2'd0,1'b0,1'b1};
  localparam logic [21:0] E_MWB       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,1'b1,1'b0,2'd0,3'd0,2'd0,1'b0,1'b0};
  localparam logic [21:0] E_MWRITE    = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,3'd0,2'd0,1'b0,1'b0};
  localparam logic [21:0] E_BEQ       = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,2'd0,3'd1,2'd1,1'b0,1'b0};
  localparam logic [21:0] E_BNE       = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,2'd0,3'd1,2'd1,1'b0,1'b0};
  localparam logic [21:0] E_JAL       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd3,1'b1,1'b0,2'd0,3'd0,2'd2,1'b0,1'b0};
  localparam logic [21:0] E_JUMP      = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,3'd0,2'd2,1'b0,1'b0};
  localparam logic [21:0] E_JR        = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,3'd0,2'd3,1'b0,1'b0};
  localparam logic [21:0] E_REXE      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,2'd0,3'd2,2'd0,1'b0,1'b0};
  localparam logic [21:0] E_RWB       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,1'b1,1'b0,2'd0,3'd0,2'd0,1'b0,1'b0};
  localparam logic [21:0] E_SLTI      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,2'd2,3'd3,2'd0,1'b0,1'b0};
  localparam logic [21:0] E_IWB       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,1'b0,2'd0,3'd0,2'd0,1'b0,1'b0};

  // DUT A outputs (TMO_CYCLES = 16)
  logic       a_pcw, a_beq, a_bne, a_iord, a_mrd, a_mwr, a_irw, a_rw, a_srca, a_ill, a_err;
  logic [1:0] a_rdst, a_m2r, a_srcb, a_pcs;
  logic [2:0] a_aop;
  logic [3:0] a_state;
  logic [21:0] a_obs;

  // DUT B outputs (TMO_CYCLES = 4)
  logic       b_pcw, b_beq, b_bne, b_iord, b_mrd, b_mwr, b_irw, b_rw, b_srca, b_ill, b_err;
  logic [1:0] b_rdst, b_m2r, b_srcb, b_pcs;
  logic [2:0] b_aop;
  logic [3:0] b_state;
  logic [21:0] b_obs;

  assign a_obs = {a_pcw, a_beq, a_bne, a_iord, a_mrd, a_mwr, a_irw, a_rdst, a_m2r,
                  a_rw, a_srca, a_srcb, a_aop, a_pcs, a_ill, a_err};
  assign b_obs = {b_pcw, b_beq, b_bne, b_iord, b_mrd, b_mwr, b_irw, b_rdst, b_m2r,
                  b_rw, b_srca, b_srcb, b_aop, b_pcs, b_ill, b_err};

  multicycle_ctrl #(.TMO_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct_i(funct), .mem_ready_i(ready_a),
    .pc_write_o(a_pcw), .pc_write_beq_o(a_beq), .pc_write_bne_o(a_bne), .iord_o(a_iord),
    .mem_read_o(a_mrd), .mem_write_o(a_mwr), .ir_write_o(a_irw), .reg_dst_o(a_rdst),
    .mem_to_reg_o(a_m2r), .reg_write_o(a_rw), .alu_src_a_o(a_srca), .alu_src_b_o(a_srcb),
    .alu_op_o(a_aop), .pc_source_o(a_pcs), .state_o(a_state), .illegal_o(a_ill),
    .mem_err_o(a_err)
  );

  multicycle_ctrl #(.TMO_CYCLES(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct_i(funct), .mem_ready_i(ready_b),
    .pc_write_o(b_pcw), .pc_write_beq_o(b_beq), .pc_write_bne_o(b_bne), .iord_o(b_iord),
    .mem_read_o(b_mrd), .mem_write_o(b_mwr), .ir_write_o(b_irw), .reg_dst_o(b_rdst),
    .mem_to_reg_o(b_m2r), .reg_write_o(b_rw), .alu_src_a_o(b_srca), .alu_src_b_o(b_srcb),
    .alu_op_o(b_aop), .pc_source_o(b_pcs), .state_o(b_state), .illegal_o(b_ill),
    .mem_err_o(b_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hold reset for a few cycles and release it on a falling edge. The next
  // rising edge moves both FSMs into FETCH.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ready_a = 1'b1;
    ready_b = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    opcode = 6'h23;
    funct = 6'h00;
    ready_a = 1'b1;
    ready_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++;
      if (a_state !== 4'd15) $display("FAIL reset_state[%0d]: got %0d expected 15", i, a_state);
      else n_pass++;
      n_checks++;
      if (a_obs !== E_ZERO) $display("FAIL reset_outputs[%0d]: got %h expected %h", i, a_obs, E_ZERO);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (a_state !== 4'd15) $display("FAIL reset_release_state: got %0d expected 15", a_state);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (a_state !== 4'd0) $display("FAIL reset_first_fetch_state: got %0d expected 0", a_state);
    else n_pass++;
    n_checks++;
    if (a_obs !== E_FETCH_RDY) $display("FAIL reset_first_fetch_ctl: got %h expected %h", a_obs, E_FETCH_RDY);
    else n_pass++;
  endtask

  task automatic test_lw();
    logic [3:0]  st_t [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [21:0] ct_t [6] = '{E_FETCH_RDY, E_DECODE, E_MADDR, E_MREAD, E_MWB, E_FETCH_RDY};
    do_reset();
    opcode = 6'h23;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ready_a = 1'b1;
      #1;
      n_checks++;
      if (a_state !== st_t[i]) $display("FAIL lw_state[%0d]: got %0d expected %0d", i, a_state, st_t[i]);
      else n_pass++;
      n_checks++;
      if (a_obs !== ct_t[i]) $display("FAIL lw_ctl[%0d]: got %h expected %h", i, a_obs, ct_t[i]);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    logic [5:0]  op_t [7] = '{6'h04, 6'h04, 6'h04, 6'h05, 6'h05, 6'h05, 6'h05};
    logic [3:0]  st_t [7] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd8, 4'd0};
    logic [21:0] ct_t [7] = '{E_FETCH_RDY, E_DECODE, E_BEQ, E_FETCH_RDY, E_DECODE, E_BNE, E_FETCH_RDY};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      opcode = op_t[i];
      ready_a = 1'b1;
      #1;
      n_checks++;
      if (a_state !== st_t[i]) $display("FAIL branch_state[%0d]: got %0d expected %0d", i, a_state, st_t[i]);
      else n_pass++;
      n_checks++;
      if (a_obs !== ct_t[i]) $display("FAIL branch_ctl[%0d]: got %h expected %h", i, a_obs, ct_t[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sw_wait();
    logic        rd_t [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  st_t [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    logic [21:0] ct_t [8] = '{E_FETCH_RDY, E_DECODE, E_MADDR, E_MWRITE, E_MWRITE, E_MWRITE,
                              E_MWRITE, E_FETCH_RDY};
    do_reset();
    opcode = 6'h2B;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ready_a = rd_t[i];
      #1;
      n_checks++;
      if (a_state !== st_t[i]) $display("FAIL sw_state[%0d]: got %0d expected %0d", i, a_state, st_t[i]);
      else n_pass++;
      n_checks++;
      if (a_obs !== ct_t[i]) $display("FAIL sw_ctl[%0d]: got %h expected %h", i, a_obs, ct_t[i]);
      else n_pass++;
    end
  endtask

  // Uses dut4 (TMO_CYCLES=4) with an lw opcode. First a FETCH timeout twice,
  // then an MREAD timeout, then a completion on the last allowed cycle.
  task automatic test_timeout();
    logic        rd_t [24] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]  st_t [24] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                               4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd0,
                               4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic [21:0] ct_t [24] = '{E_FETCH_WT, E_FETCH_WT, E_FETCH_WT, E_FETCH_TMO,
                               E_FETCH_WT, E_FETCH_WT, E_FETCH_WT, E_FETCH_TMO,
                               E_FETCH_RDY, E_DECODE, E_MADDR, E_MREAD,
                               E_MREAD, E_MREAD, E_MREAD_TMO, E_FETCH_RDY,
                               E_DECODE, E_MADDR, E_MREAD, E_MREAD,
                               E_MREAD, E_MREAD, E_MWB, E_FETCH_RDY};
    do_reset();
    opcode = 6'h23;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      ready_b = rd_t[i];
      #1;
      n_checks++;
      if (b_state !== st_t[i]) $display("FAIL tmo_state[%0d]: got %0d expected %0d", i, b_state, st_t[i]);
      else n_pass++;
      n_checks++;
      if (b_obs !== ct_t[i]) $display("FAIL tmo_ctl[%0d]: got %h expected %h", i, b_obs, ct_t[i]);
      else n_pass++;
    end
  endtask

  task automatic test_jal_illegal();
    logic [5:0]  op_t [6] = '{6'h03, 6'h03, 6'h03, 6'h3F, 6'h3F, 6'h3F};
    logic [3:0]  st_t [6] = '{4'd0, 4'd1, 4'd13, 4'd0, 4'd1, 4'd0};
    logic [21:0] ct_t [6] = '{E_FETCH_RDY, E_DECODE, E_JAL, E_FETCH_RDY, E_DEC_ILL, E_FETCH_RDY};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      opcode = op_t[i];
      ready_a = 1'b1;
      #1;
      n_checks++;
      if (a_state !== st_t[i]) $display("FAIL jal_ill_state[%0d]: got %0d expected %0d", i, a_state, st_t[i]);
      else n_pass++;
      n_checks++;
      if (a_obs !== ct_t[i]) $display("FAIL jal_ill_ctl[%0d]: got %h expected %h", i, a_obs, ct_t[i]);
      else n_pass++;
    end
  endtask

  // R-type add, jr, slti and j back to back.
  task automatic test_back_to_back();
    logic [5:0]  op_t [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                               6'h0A, 6'h0A, 6'h0A, 6'h02, 6'h02, 6'h02};
    logic [5:0]  fn_t [13] = '{6'h20, 6'h20, 6'h20, 6'h20, 6'h08, 6'h08, 6'h08,
                               6'h08, 6'h08, 6'h08, 6'h08, 6'h08, 6'h08};
    logic [3:0]  st_t [13] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd12,
                               4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd1};
    logic [21:0] ct_t [13] = '{E_FETCH_RDY, E_DECODE, E_REXE, E_RWB, E_FETCH_RDY, E_DECODE, E_JR,
                               E_FETCH_RDY, E_DECODE, E_SLTI, E_IWB, E_FETCH_RDY, E_DECODE};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      opcode = op_t[i];
      funct = fn_t[i];
      ready_a = 1'b1;
      #1;
      n_checks++;
      if (a_state !== st_t[i]) $display("FAIL b2b_state[%0d]: got %0d expected %0d", i, a_state, st_t[i]);
      else n_pass++;
      n_checks++;
      if (a_obs !== ct_t[i]) $display("FAIL b2b_ctl[%0d]: got %h expected %h", i, a_obs, ct_t[i]);
      else n_pass++;
    end
    // The j instruction dispatched above lands in JUMP.
    @(negedge clk);
    #1;
    n_checks++;
    if (a_state !== 4'd9) $display("FAIL jump_state: got %0d expected 9", a_state);
    else n_pass++;
    n_checks++;
    if (a_obs !== E_JUMP) $display("FAIL jump_ctl: got %h expected %h", a_obs, E_JUMP);
    else n_pass++;
  endtask

  // Reset asserted mid-store: the write strobe must drop at once.
  task automatic test_reset_abort();
    do_reset();
    opcode = 6'h2B;
    repeat (3) @(negedge clk);
    ready_a = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (a_obs !== E_MWRITE) $display("FAIL abort_pre_ctl: got %h expected %h", a_obs, E_MWRITE);
    else n_pass++;
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (a_state !== 4'd15) $display("FAIL abort_state: got %0d expected 15", a_state);
    else n_pass++;
    n_checks++;
    if (a_obs !== E_ZERO) $display("FAIL abort_ctl: got %h expected %h", a_obs, E_ZERO);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    ready_a = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (a_state !== 4'd0) $display("FAIL abort_refetch_state: got %0d expected 0", a_state);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst = 1'b0;
    opcode = 6'h00;
    funct = 6'h00;
    ready_a = 1'b1;
    ready_b = 1'b1;
    test_reset();
    test_lw();
    test_branch();
    test_sw_wait();
    test_timeout();
    test_jal_illegal();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
